div_config: RTL

- Sequential sign-magnitude divider: the inverse of the sign-magnitude multiplier.
- Takes an (M+N)-bit sign-magnitude dividend (multiplier product format) and an N-bit sign-magnitude divisor.
- Returns an M-bit sign-magnitude quotient and an N-bit sign-magnitude remainder.
- Restoring division, one quotient bit per clock; used for rescaling/normalising accumulated products in the LeNet datapath.

---
 rtl/div_config.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/div_config.sv
`default_nettype none
// ============================================================================
//  Module      : div_config
//  Description : Sequential sign-magnitude restoring divider. It divides an
//                (M+N)-bit sign-magnitude dividend by an N-bit sign-magnitude
//                divisor and produces one quotient bit per clock. The results
//                are an M-bit sign-magnitude quotient, saturated with an
//                ovf flag, and an N-bit sign-magnitude remainder. A zero
//                divisor magnitude completes in one cycle with dz set.
//
//  Ports       : clk        system clock, rising edge
//                rst        asynchronous active-high reset
//                DIV_a      dividend  [M+N-1:0], MSB = sign
//                DIV_b      divisor   [N-1:0],   MSB = sign
//                DIV_start  request, sampled only while DIV_busy = 0
//                DIV_busy   division in progress
//                DIV_done   one-cycle completion pulse
//                quo        quotient  [M-1:0], sign-magnitude
//                rem        remainder [N-1:0], sign-magnitude
//                ovf        quotient magnitude saturated
//                dz         divide by zero
//
//  Revision    : 1.0 - initial release
// ============================================================================
module div_config #(
    parameter int M = 8,
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [M+N-1:0]   DIV_a,
    input  logic [N-1:0]     DIV_b,
    input  logic             DIV_start,
    output logic             DIV_busy,
    output logic             DIV_done,
    output logic [M-1:0]     quo,
    output logic [N-1:0]     rem,
    output logic             ovf,
    output logic             dz
);

    // Dividend magnitude width; this is also the full quotient width
    localparam int W  = M + N - 1;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_a_mag;   // dividend magnitude, shifted out MSB first
    logic [N-2:0]    r_b_mag;   // divisor magnitude
    logic            r_sa;
    logic            r_sb;
    logic [CW-1:0]   r_cnt;
    logic [N-2:0]    r_prem;    // partial remainder, always < divisor
    logic [W-2:0]    r_q;       // quotient bits collected so far

    // One restoring step. The shifted value needs one guard bit above the
    // remainder width. A successful subtraction leaves a result below the
    // divisor, so the low N-1 bits of the modular difference are exact.
    logic [N-1:0]    w_shift;
    logic            w_qbit;
    logic [N-2:0]    w_diff;
    logic [N-2:0]    w_prem_next;
    logic [W-1:0]    w_q_next;
    logic            w_ovf;
    logic [M-2:0]    w_quo_mag;
    logic [N-2:0]    w_rem_mag;
    logic            w_b_zero;

    assign w_shift     = {r_prem, r_a_mag[W-1]};
    assign w_qbit      = (w_shift >= {1'b0, r_b_mag});
    assign w_diff      = w_shift[N-2:0] - r_b_mag;
    assign w_prem_next = w_qbit ? w_diff : w_shift[N-2:0];
    assign w_q_next    = {r_q, w_qbit};

    // Saturate when any quotient bit lands above the output magnitude range
    assign w_ovf       = |w_q_next[W-1:M-1];
    assign w_quo_mag   = w_ovf ? {(M-1){1'b1}} : w_q_next[M-2:0];
    assign w_rem_mag   = w_prem_next;
    assign w_b_zero    = (DIV_b[N-2:0] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a_mag  <= '0;
            r_b_mag  <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_cnt    <= '0;
            r_prem   <= '0;
            r_q      <= '0;
            DIV_busy <= 1'b0;
            DIV_done <= 1'b0;
            quo      <= '0;
            rem      <= '0;
            ovf      <= 1'b0;
            dz       <= 1'b0;
        end else begin
            DIV_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (DIV_start) begin
                        r_a_mag <= DIV_a[W-1:0];
                        r_b_mag <= DIV_b[N-2:0];
                        r_sa    <= DIV_a[M+N-1];
                        r_sb    <= DIV_b[N-1];
                        if (w_b_zero) begin
                            // Magnitude is all ones, so the sign is kept
                            DIV_done <= 1'b1;
                            dz       <= 1'b1;
                            ovf      <= 1'b0;
                            quo      <= {DIV_a[M+N-1] ^ DIV_b[N-1], {(M-1){1'b1}}};
                            rem      <= '0;
                        end else begin
                            r_state  <= CALC;
                            r_cnt    <= CW'(W - 1);
                            r_prem   <= '0;
                            r_q      <= '0;
                            DIV_busy <= 1'b1;
                        end
                    end
                end

                CALC: begin
                    r_a_mag <= {r_a_mag[W-2:0], 1'b0};
                    r_prem  <= w_prem_next;
                    r_q     <= w_q_next[W-2:0];
                    r_cnt   <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_state  <= IDLE;
                        DIV_busy <= 1'b0;
                        DIV_done <= 1'b1;
                        ovf      <= w_ovf;
                        dz       <= 1'b0;
                        // Zero magnitudes never carry a sign
                        quo      <= {(r_sa ^ r_sb) & (|w_quo_mag), w_quo_mag};
                        rem      <= {r_sa & (|w_rem_mag), w_rem_mag};
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
